lvds_pll_lock_seq: RTL and testbench

Reset/lock sequencer for the LVDS receive PLL in the DAS board design; the PLL is the source-synchronous 250 MHz-ref PLL with 500 MHz serial and 62.5 MHz frame/core clocks.
- Pulses the PLL reset, waits for lock with a timeout, and qualifies lock as stable over a window.
- Sequences the downstream LVDS receiver/deserializer reset, then asserts ready.
- Monitors for loss of lock and retries automatically; enters a latched fault after too many failed attempts.
- Runs on a free-running system clock that is independent of the PLL outputs.

---
 rtl/lvds_pll_seq_pkg.sv | 51 +++++
 rtl/sync_2ff.sv | 22 ++
 rtl/lvds_pll_lock_seq.sv | 170 +++++++++++++++++
 tb/tb_lvds_pll_lock_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pll_seq_pkg.sv
// Shared types and helpers for the LVDS receive-PLL reset/lock sequencer.
// State encoding is fixed because the debug state_o port is decoded by
// board software.
package lvds_pll_seq_pkg;

    localparam int STATE_W   = 3;
    localparam int LOL_CNT_W = 16;
    localparam int RETRY_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RX_RST    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    typedef struct packed {
        logic pll_rst;
        logic rx_rst;
        logic ready;
        logic fault;
    } seq_out_t;

    // Output levels for a given state. Unused codes read as PLL_RST, which
    // keeps both resets asserted.
    function automatic seq_out_t decode_outputs(input logic [STATE_W-1:0] st);
        seq_out_t o;
        o = '{pll_rst: 1'b1, rx_rst: 1'b1, ready: 1'b0, fault: 1'b0};
        case (st)
            ST_WAIT_LOCK,
            ST_STABLE,
            ST_RX_RST: o.pll_rst = 1'b0;
            ST_RUN: begin
                o.pll_rst = 1'b0;
                o.rx_rst  = 1'b0;
                o.ready   = 1'b1;
            end
            ST_FAULT: o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Saturating increment for the loss-of-lock event counter.
    function automatic logic [LOL_CNT_W-1:0] sat_inc_lol(input logic [LOL_CNT_W-1:0] v);
        return (&v) ? v : v + LOL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-register synchronizer for bringing an asynchronous
// level into the clk domain. Output latency is two clk edges.
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous input, then re-register to let metastability settle.
    // NOTE: no reset on these flops; the chain flushes to the true input level
    // within two cycles, so a reset value would only add routing.
    always_ff @(posedge clk) begin
        meta_q <= d;
        sync_q <= meta_q;
    end

    assign q = sync_q;

endmodule

// File: rtl/lvds_pll_lock_seq.sv
// Reset/lock sequencer for the LVDS receive PLL: pulses pll_rst, waits for
// lock with a timeout, qualifies lock over a stable window, releases the
// deserializer reset and then raises ready. Loss of lock restarts the
// sequence; too many failed lock attempts latch fault until relock_req.
// Optional build macro LVDS_PLL_SEQ_LOL_CNT_EN enables the loss-of-lock
// event counter on lol_cnt (tied to zero otherwise).
module lvds_pll_lock_seq
    import lvds_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RX_RST_CYCLES       = 32,
    parameter int MAX_RETRIES         = 7,
    parameter int CNT_W               = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 relock_req,
    output logic                 pll_rst,
    output logic                 rx_rst,
    output logic                 ready,
    output logic                 fault,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [STATE_W-1:0]   state_o,
    output logic [LOL_CNT_W-1:0] lol_cnt
);

    localparam logic [STATE_W-1:0] S_PLL_RST   = ST_PLL_RST;
    localparam logic [STATE_W-1:0] S_WAIT_LOCK = ST_WAIT_LOCK;
    localparam logic [STATE_W-1:0] S_STABLE    = ST_STABLE;
    localparam logic [STATE_W-1:0] S_RX_RST    = ST_RX_RST;
    localparam logic [STATE_W-1:0] S_RUN       = ST_RUN;
    localparam logic [STATE_W-1:0] S_FAULT     = ST_FAULT;

    // Timer is loaded with (cycles - 1) so a state lasts exactly "cycles".
    localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RX      = CNT_W'(RX_RST_CYCLES - 1);
    localparam logic [RETRY_W-1:0] MAX_R    = RETRY_W'(MAX_RETRIES);

    logic                 lk;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [RETRY_W-1:0]   retry_inc;
    seq_out_t             out_q, out_d;
    logic                 timer_zero;

    sync_2ff u_lock_sync (
        .clk (clk),
        .d   (pll_locked),
        .q   (lk)
    );

    assign timer_zero = (timer_q == '0);
    assign retry_inc  = retry_q + RETRY_W'(1);

    // Next-state and retry bookkeeping; relock_req overrides everything.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch cannot be inferred.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            S_PLL_RST: begin
                if (timer_zero) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                end else if (timer_zero) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == MAX_R) ? S_FAULT : S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!lk)             state_d = S_WAIT_LOCK;
                else if (timer_zero) state_d = S_RX_RST;
            end
            S_RX_RST: begin
                if (!lk)             state_d = S_PLL_RST;
                else if (timer_zero) state_d = S_RUN;
            end
            S_RUN: begin
                if (!lk) state_d = S_PLL_RST;
            end
            S_FAULT: ;
            default: state_d = S_PLL_RST;
        endcase
        if (state_d == S_RUN) retry_d = '0;
        if (relock_req) begin
            state_d = S_PLL_RST;
            retry_d = '0;
        end
    end

    // Timer reloads on every state entry (including relock into PLL_RST), else counts down to 0.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || relock_req) begin
            case (state_d)
                S_PLL_RST:   timer_d = LD_PULSE;
                S_WAIT_LOCK: timer_d = LD_TIMEOUT;
                S_STABLE:    timer_d = LD_STABLE;
                S_RX_RST:    timer_d = LD_RX;
                default:     timer_d = '0;
            endcase
        end else if (!timer_zero) begin
            timer_d = timer_q - CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so the registered copy tracks state_q exactly.
    always_comb begin
        out_d = decode_outputs(state_d);
    end

    // State, timer, retry and output registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PLL_RST;
            timer_q <= '0;
            retry_q <= '0;
            out_q   <= decode_outputs(S_PLL_RST);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    assign pll_rst   = out_q.pll_rst;
    assign rx_rst    = out_q.rx_rst;
    assign ready     = out_q.ready;
    assign fault     = out_q.fault;
    assign retry_cnt = retry_q;
    assign state_o   = state_q;

`ifdef LVDS_PLL_SEQ_LOL_CNT_EN
    logic                 lol_evt;
    logic [LOL_CNT_W-1:0] lol_q, lol_d;

    // A loss-of-lock event is lk falling while rx is being released or running,
    // counted even when relock_req lands on the same cycle.
    assign lol_evt = ((state_q == S_RUN) || (state_q == S_RX_RST)) && !lk;

    // Saturating event count; only rst clears it.
    always_comb begin
        lol_d = lol_q;
        if (lol_evt) lol_d = sat_inc_lol(lol_q);
    end

    // Loss-of-lock counter register.
    always_ff @(posedge clk) begin
        if (rst) lol_q <= '0;
        else     lol_q <= lol_d;
    end

    assign lol_cnt = lol_q;
`else
    assign lol_cnt = '0;
`endif

endmodule

// File: tb/tb_lvds_pll_lock_seq.sv
// Directed bench for lvds_pll_lock_seq with a scoreboard queue: expected
// values are queued as each step is driven and popped when the DUT output
// is sampled (#1 after the active edge).
module tb_lvds_pll_lock_seq;

    localparam int SEL_READY   = 0;
    localparam int SEL_PLL_RST = 1;
    localparam int SEL_STATE   = 2;
    localparam int SEL_FAULT   = 3;

`ifdef LVDS_PLL_SEQ_LOL_CNT_EN
    localparam logic [31:0] LOL_ONE = 32'd1;
    localparam logic [31:0] LOL_TWO = 32'd2;
`else
    localparam logic [31:0] LOL_ONE = 32'd0;
    localparam logic [31:0] LOL_TWO = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pll_locked;
    logic        relock_req;
    logic        pll_rst;
    logic        rx_rst;
    logic        ready;
    logic        fault;
    logic [7:0]  retry_cnt;
    logic [2:0]  state_o;
    logic [15:0] lol_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lvds_pll_lock_seq #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (50),
        .LOCK_STABLE_CYCLES  (8),
        .RX_RST_CYCLES       (4),
        .MAX_RETRIES         (3),
        .CNT_W               (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .rx_rst     (rx_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_o    (state_o),
        .lol_cnt    (lol_cnt)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock; also enforces ready => no reset and no fault on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ready === 1'b1) begin
            checks++;
            assert ({rx_rst, pll_rst, fault} === 3'b000) else begin
                failures++;
                $error("FAIL ready_invariant observed=%b expected=000", {rx_rst, pll_rst, fault});
            end
        end
    endtask

    function automatic logic [31:0] sel_val(input int sel);
        case (sel)
            SEL_READY:   return 32'(ready);
            SEL_PLL_RST: return 32'(pll_rst);
            SEL_STATE:   return 32'(state_o);
            default:     return 32'(fault);
        endcase
    endfunction

    // Ticks until the selected output equals val; n is the number of ticks (budget on expiry).
    task automatic wait_sig(input int sel, input logic [31:0] val, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((sel_val(sel) !== val) && (n < budget));
    endtask

    // Width of a pll_rst pulse that is already high at the current sample.
    task automatic measure_pulse(output int w);
        w = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pll_rst !== 1'b1) break;
            w++;
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        expect_val({pfx, "_pll_rst"}, 32'd1);   check(32'(pll_rst));
        expect_val({pfx, "_rx_rst"}, 32'd1);    check(32'(rx_rst));
        expect_val({pfx, "_ready"}, 32'd0);     check(32'(ready));
        expect_val({pfx, "_fault"}, 32'd0);     check(32'(fault));
        expect_val({pfx, "_retry"}, 32'd0);     check(32'(retry_cnt));
        expect_val({pfx, "_state"}, 32'd0);     check(32'(state_o));
        expect_val({pfx, "_lol"}, 32'd0);       check(32'(lol_cnt));
    endtask

    initial begin
        int n;
        int w;

        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        check_reset_vals("por");

        // Reset release: the reset period itself serves as the first pulse.
        rst = 1'b0;
        expect_val("release_pll_rst_fall", 32'd1);
        wait_sig(SEL_PLL_RST, 32'd0, 10, n);
        check(32'(n));

        // Nominal lock 10 cycles after pll_rst falls: 2 sync + 1 + 8 stable + 4 rx.
        repeat (10) tick();
        pll_locked = 1'b1;
        expect_val("nom_ready_latency", 32'd15);
        wait_sig(SEL_READY, 32'd1, 40, n);
        check(32'(n));
        expect_val("nom_rx_rst", 32'd0);  check(32'(rx_rst));
        expect_val("nom_retry", 32'd0);   check(32'(retry_cnt));
        expect_val("nom_state", 32'd4);   check(32'(state_o));

        // Loss of lock in RUN.
        pll_locked = 1'b0;
        expect_val("lol_ready_fall", 32'd3);
        wait_sig(SEL_READY, 32'd0, 10, n);
        check(32'(n));
        expect_val("lol_pll_rst", 32'd1); check(32'(pll_rst));
        expect_val("lol_state", 32'd0);   check(32'(state_o));
        expect_val("lol_cnt_1", LOL_ONE); check(32'(lol_cnt));
        pll_locked = 1'b1;
        expect_val("lol_pulse_width", 32'd4);
        measure_pulse(w);
        check(32'(w));
        wait_sig(SEL_READY, 32'd1, 60, n);
        expect_val("lol_ready_again", 32'd1); check(32'(ready));
        expect_val("lol_cnt_hold", LOL_ONE);  check(32'(lol_cnt));

        // relock_req in RUN with lock held: back through PLL_RST into STABLE.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        expect_val("relock_state", 32'd0); check(32'(state_o));
        expect_val("relock_ready", 32'd0); check(32'(ready));
        expect_val("relock_to_stable", 32'd5);
        wait_sig(SEL_STATE, 32'd2, 20, n);
        check(32'(n));

        // One-cycle glitch at stable count 5; lk=0 lands on the window-expiry cycle.
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        expect_val("glitch_to_wait_lock", 32'd2);
        wait_sig(SEL_STATE, 32'd1, 10, n);
        check(32'(n));
        expect_val("glitch_retry", 32'd0); check(32'(retry_cnt));
        expect_val("glitch_ready_delay", 32'd13);
        wait_sig(SEL_READY, 32'd1, 40, n);
        check(32'(n));

        // relock_req arriving on the same cycle lk falls in RUN.
        pll_locked = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        expect_val("rl_lol_state", 32'd0);   check(32'(state_o));
        expect_val("rl_lol_retry", 32'd0);   check(32'(retry_cnt));
        expect_val("rl_lol_ready", 32'd0);   check(32'(ready));
        expect_val("rl_lol_cnt", LOL_TWO);   check(32'(lol_cnt));
        expect_val("rl_lol_single_pulse", 32'd4);
        measure_pulse(w);
        check(32'(w));

        // Lock never arrives: two more 4-cycle pulses, retry 1,2, then fault at 3.
        for (int i = 1; i <= 2; i++) begin
            expect_val("to_wait_cycles", 32'd50);
            wait_sig(SEL_PLL_RST, 32'd1, 80, n);
            check(32'(n));
            expect_val("to_retry", 32'(i));
            check(32'(retry_cnt));
            expect_val("to_pulse_width", 32'd4);
            measure_pulse(w);
            check(32'(w));
        end
        expect_val("fault_wait_cycles", 32'd50);
        wait_sig(SEL_FAULT, 32'd1, 80, n);
        check(32'(n));
        expect_val("fault_retry", 32'd3);   check(32'(retry_cnt));
        expect_val("fault_pll_rst", 32'd1); check(32'(pll_rst));
        expect_val("fault_rx_rst", 32'd1);  check(32'(rx_rst));
        expect_val("fault_state", 32'd5);   check(32'(state_o));
        repeat (10) tick();
        expect_val("fault_latched", 32'd1); check(32'(fault));

        // relock_req clears the fault and starts a fresh pulse.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        expect_val("clr_fault", 32'd0);   check(32'(fault));
        expect_val("clr_retry", 32'd0);   check(32'(retry_cnt));
        expect_val("clr_state", 32'd0);   check(32'(state_o));
        expect_val("clr_pulse_width", 32'd4);
        measure_pulse(w);
        check(32'(w));

        // Synchronous reset in the middle of RX_RST.
        pll_locked = 1'b1;
        wait_sig(SEL_STATE, 32'd3, 80, n);
        expect_val("mid_rx_rst_state", 32'd3); check(32'(state_o));
        rst = 1'b1;
        tick();
        check_reset_vals("mid_rst");
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
